// File: rtl/iter_alu_if.sv
// Handshake and operand/result bundle between the register-file read stage,
// iter_alu and the write-back mux.
interface iter_alu_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             ready_o;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             overflow_o;
  logic             valid_o;

  modport master (
    output start_i, src1_i, src2_i, ctrl_i,
    input  ready_o, result_o, zero_o, overflow_o, valid_o
  );

  modport slave (
    input  start_i, src1_i, src2_i, ctrl_i,
    output ready_o, result_o, zero_o, overflow_o, valid_o
  );
endinterface

// File: rtl/iter_alu.sv
// Registered ALU with valid/ready handshake: single-cycle logic/arith/shift/compare
// ops and a fixed-latency (WIDTH-cycle) iterative shift-add multiplier.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  iter_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_MUL  = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTU = 4'd8,
    OP_NOR  = 4'd12
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   count;

  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  logic [WIDTH-1:0] acc_next;

  assign ready       = (state == ST_IDLE);
  assign bus.ready_o = ready;
  assign accept      = bus.start_i && ready;

  assign sum   = bus.src1_i + bus.src2_i;
  assign diff  = bus.src1_i - bus.src2_i;
  assign shamt = bus.src2_i[SHW-1:0];

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise unlisted opcodes would infer latches.
  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (bus.ctrl_i)
      OP_AND:  alu_result = bus.src1_i & bus.src2_i;
      OP_OR:   alu_result = bus.src1_i | bus.src2_i;
      OP_ADD: begin
        alu_result = sum;
        alu_ovf    = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                     (sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result = diff;
        alu_ovf    = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                     (diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      OP_SLL:  alu_result = bus.src1_i << shamt;
      OP_SRL:  alu_result = bus.src1_i >> shamt;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, $signed(bus.src1_i) < $signed(bus.src2_i)};
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, bus.src1_i < bus.src2_i};
      OP_NOR:  alu_result = ~(bus.src1_i | bus.src2_i);
      default: begin
        alu_result = '0;
        alu_ovf    = 1'b0;
      end
    endcase
  end

  // One shift-add step; the final step's sum is what gets written on completion.
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= ST_IDLE;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      count          <= '0;
      bus.result_o   <= '0;
      bus.zero_o     <= 1'b1;
      bus.overflow_o <= 1'b0;
      bus.valid_o    <= 1'b0;
    end else begin
      bus.valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bus.ctrl_i == OP_MUL) begin
              mcand  <= bus.src1_i;
              mplier <= bus.src2_i;
              acc    <= '0;
              count  <= '0;
              state  <= ST_MUL;
            end else begin
              bus.result_o   <= alu_result;
              bus.zero_o     <= (alu_result == '0);
              bus.overflow_o <= alu_ovf;
              bus.valid_o    <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == SHW'(WIDTH - 1)) begin
            bus.result_o   <= acc_next;
            bus.zero_o     <= (acc_next == '0);
            bus.overflow_o <= 1'b0;
            bus.valid_o    <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: cycle-level reference model compared every
// cycle, plus directed vectors with hand-computed literal results.
module tb_iter_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iter_alu_if #(.WIDTH(W)) bus ();
  iter_alu #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {overflow, result}.
  function automatic logic [W:0] ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         ovf;
    logic [63:0]  p;
    longint       s;
    r   = '0;
    ovf = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2: begin
        r   = a + b;
        s   = longint'($signed(a)) + longint'($signed(b));
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd3: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[W-1:0];
      end
      4'd4:  r = a << (b % W);
      4'd5:  r = a >> (b % W);
      4'd6: begin
        r   = a - b;
        s   = longint'($signed(a)) - longint'($signed(b));
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd8:  r = (a < b) ? 1 : 0;
      4'd12: r = ~(a | b);
      default: r = '0;
    endcase
    return {ovf, r};
  endfunction

  // Cycle-level model state.
  int           mul_left = 0;
  logic [W-1:0] mul_pending;
  logic [W-1:0] m_result;
  logic         m_zero, m_ovf, m_valid;
  logic [W:0]   tmp;

  always @(posedge clk) begin
    if (rst) begin
      mul_left = 0;
      m_result = '0;
      m_zero   = 1'b1;
      m_ovf    = 1'b0;
      m_valid  = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin
          m_result = mul_pending;
          m_zero   = (mul_pending == 0);
          m_ovf    = 1'b0;
          m_valid  = 1'b1;
        end
      end else if (bus.start_i) begin
        tmp = ref_op(bus.ctrl_i, bus.src1_i, bus.src2_i);
        if (bus.ctrl_i == 4'd3) begin
          mul_left    = W;
          mul_pending = tmp[W-1:0];
        end else begin
          m_result = tmp[W-1:0];
          m_zero   = (tmp[W-1:0] == 0);
          m_ovf    = tmp[W];
          m_valid  = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",  bus.ready_o,    (mul_left == 0));
      check("valid",  bus.valid_o,    m_valid);
      check("result", bus.result_o,   m_result);
      check("zero",   bus.zero_o,     m_zero);
      check("ovf",    bus.overflow_o, m_ovf);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start_i = 1'b1;
    bus.ctrl_i  = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.valid_o && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("valid_seen", bus.valid_o, 1'b1);
  endtask

  int cyc;

  initial begin
    bus.start_i = 1'b0;
    bus.ctrl_i  = '0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state after idling.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  bus.ready_o,    1'b1);
    check("rst_valid",  bus.valid_o,    1'b0);
    check("rst_result", bus.result_o,   32'h0);
    check("rst_zero",   bus.zero_o,     1'b1);
    check("rst_ovf",    bus.overflow_o, 1'b0);

    // Back-to-back single-cycle ops.
    issue(4'd2, 32'h7FFF_FFFF, 32'h1);
    check("add_res", bus.result_o, 32'h8000_0000);
    check("add_ovf", bus.overflow_o, 1'b1);
    check("add_vld", bus.valid_o, 1'b1);
    issue(4'd6, 32'h0, 32'h1);
    check("sub_res", bus.result_o, 32'hFFFF_FFFF);
    check("sub_ovf", bus.overflow_o, 1'b0);
    check("sub_vld", bus.valid_o, 1'b1);
    issue(4'd12, 32'h0, 32'h0);
    check("nor_res", bus.result_o, 32'hFFFF_FFFF);
    check("nor_vld", bus.valid_o, 1'b1);
    check("nor_rdy", bus.ready_o, 1'b1);
    @(posedge clk);
    #1;
    check("vld_drop", bus.valid_o, 1'b0);

    // Compare, shift, undefined opcode, sub overflow, logic ops.
    issue(4'd7, 32'hFFFF_FFFF, 32'h1);
    check("slt_res", bus.result_o, 32'h1);
    issue(4'd8, 32'hFFFF_FFFF, 32'h1);
    check("sltu_res", bus.result_o, 32'h0);
    check("sltu_zero", bus.zero_o, 1'b1);
    issue(4'd4, 32'h1, 32'h21);
    check("sll_res", bus.result_o, 32'h2);
    issue(4'd9, 32'h1234, 32'h5678);
    check("op9_res", bus.result_o, 32'h0);
    check("op9_zero", bus.zero_o, 1'b1);
    check("op9_vld", bus.valid_o, 1'b1);
    issue(4'd6, 32'h8000_0000, 32'h1);
    check("sub_ovf2", bus.overflow_o, 1'b1);
    check("sub_res2", bus.result_o, 32'h7FFF_FFFF);
    issue(4'd5, 32'h8000_0000, 32'h1F);
    check("srl_res", bus.result_o, 32'h1);
    issue(4'd0, 32'hF0F0_FFFF, 32'h0FF0_00F0);
    check("and_res", bus.result_o, 32'h00F0_00F0);
    issue(4'd1, 32'hF000_0000, 32'h0000_000F);
    check("or_res", bus.result_o, 32'hF000_000F);
    issue(4'd7, 32'h1, 32'hFFFF_FFFF);
    check("slt_res2", bus.result_o, 32'h0);

    // MUL latency and value.
    issue(4'd3, 32'd7, 32'd6);
    check("mul_busy", bus.ready_o, 1'b0);
    wait_valid(cyc);
    check("mul_lat", cyc, 32);
    check("mul_res", bus.result_o, 32'd42);
    check("mul_ovf", bus.overflow_o, 1'b0);
    issue(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(cyc);
    check("mul_res2", bus.result_o, 32'h1);

    // MUL with start held high carrying an ADD; ADD must wait for ready.
    bus.start_i = 1'b1;
    bus.ctrl_i  = 4'd3;
    bus.src1_i  = 32'h0001_0000;
    bus.src2_i  = 32'h0001_0000;
    @(posedge clk);
    #1;
    bus.ctrl_i = 4'd2;
    bus.src1_i = 32'd1;
    bus.src2_i = 32'd1;
    wait_valid(cyc);
    check("mulz_lat",  cyc, 32);
    check("mulz_res",  bus.result_o, 32'h0);
    check("mulz_zero", bus.zero_o, 1'b1);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    check("add_after_vld", bus.valid_o, 1'b1);
    check("add_after_res", bus.result_o, 32'd2);

    // Reset aborts MUL.
    issue(4'd3, 32'd9, 32'd9);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_vld",  bus.valid_o,  1'b0);
    check("abort_rdy",  bus.ready_o,  1'b1);
    check("abort_res",  bus.result_o, 32'h0);
    check("abort_zero", bus.zero_o,   1'b1);
    repeat (30) @(posedge clk);
    #1;
    check("abort_quiet", bus.result_o, 32'h0);
    issue(4'd3, 32'd3, 32'd5);
    wait_valid(cyc);
    check("mul2_lat", cyc, 32);
    check("mul2_res", bus.result_o, 32'd15);
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
